inv_key_schedule_buffer: RTL and testbench

INV_KEY_SCHEDULE_BUFFER -- requirements
Module: inv_key_schedule_buffer

---
 rtl/inv_key_schedule_buffer_pkg.sv | 32 +++
 rtl/inv_key_schedule_buffer_inv_mix_columns.sv | 29 ++
 rtl/inv_key_schedule_buffer.sv | 129 ++++++++++++
 tb/tb_inv_key_schedule_buffer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_key_schedule_buffer_pkg.sv
// rtl/inv_key_schedule_buffer_pkg.sv - shared AES types, constants and GF(2^8) helpers
package inv_key_schedule_buffer_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_RKEYS  = 11;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_OUT,
        ST_HOLD
    } state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply a byte by a 4-bit constant (enough for 9, 11, 13, 14).
    function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? b  : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_key_schedule_buffer_inv_mix_columns.sv
// rtl/inv_key_schedule_buffer_inv_mix_columns.sv - combinational AES InvMixColumns
// Ports: data   - 128-bit state, byte 0 in bits [127:120], column-major
//        result - InvMixColumns(data)
module inv_key_schedule_buffer_inv_mix_columns
    import inv_key_schedule_buffer_pkg::*;
(
    input  block_t data,
    output block_t result
);

    always_comb begin
        logic [7:0] a [4];
        result = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r] = data[127 - 8 * (4 * c + r) -: 8];
            end
            result[127 - 8 * (4 * c + 0) -: 8] = gf_mul_const(a[0], 4'd14) ^ gf_mul_const(a[1], 4'd11) ^
                                                 gf_mul_const(a[2], 4'd13) ^ gf_mul_const(a[3], 4'd9);
            result[127 - 8 * (4 * c + 1) -: 8] = gf_mul_const(a[0], 4'd9)  ^ gf_mul_const(a[1], 4'd14) ^
                                                 gf_mul_const(a[2], 4'd11) ^ gf_mul_const(a[3], 4'd13);
            result[127 - 8 * (4 * c + 2) -: 8] = gf_mul_const(a[0], 4'd13) ^ gf_mul_const(a[1], 4'd9) ^
                                                 gf_mul_const(a[2], 4'd14) ^ gf_mul_const(a[3], 4'd11);
            result[127 - 8 * (4 * c + 3) -: 8] = gf_mul_const(a[0], 4'd11) ^ gf_mul_const(a[1], 4'd13) ^
                                                 gf_mul_const(a[2], 4'd9)  ^ gf_mul_const(a[3], 4'd14);
        end
    end

endmodule

// File: rtl/inv_key_schedule_buffer.sv
// rtl/inv_key_schedule_buffer.sv - buffers 11 forward round keys and replays them in decryption order
// Ports: Clk, Rst_n (sync active-low), Clear (sync abort)
//        KeyInValid/KeyInReady/KeyIn       - forward round keys rk0..rk10 in order
//        KeyOutValid/KeyOutReady/KeyOut    - decryption round keys dk0..dk10
//        KeyOutIdx, KeyOutLast             - current dk index and last-key flag
//        Replay                            - in HOLD, restart readout without reloading
module inv_key_schedule_buffer
    import inv_key_schedule_buffer_pkg::*;
#(
    parameter int EQUIV_INV = 1
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Clear,
    input  logic         KeyInValid,
    output logic         KeyInReady,
    input  logic [127:0] KeyIn,
    output logic         KeyOutValid,
    input  logic         KeyOutReady,
    output logic [127:0] KeyOut,
    output logic [3:0]   KeyOutIdx,
    output logic         KeyOutLast,
    input  logic         Replay
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    state_t     state, state_nxt;
    logic [3:0] wp, wp_nxt;
    logic [3:0] j, j_nxt;
    logic       buf_we;
    block_t     key_buf [NUM_RKEYS];
    block_t     sel_word;
    block_t     imc_word;
    logic [3:0] rd_idx;
    logic       pass_through;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state <= ST_LOAD;
            wp    <= '0;
            j     <= '0;
        end else begin
            state <= state_nxt;
            wp    <= wp_nxt;
            j     <= j_nxt;
        end
    end

    // Buffer contents are don't-care after reset, so no reset branch here.
    always_ff @(posedge Clk) begin
        if (buf_we) begin
            key_buf[wp] <= KeyIn;
        end
    end

    always_comb begin
        state_nxt   = state;
        wp_nxt      = wp;
        j_nxt       = j;
        buf_we      = 1'b0;
        KeyInReady  = 1'b0;
        KeyOutValid = 1'b0;
        case (state)
            ST_LOAD: begin
                KeyInReady = 1'b1;
                if (KeyInValid) begin
                    buf_we = 1'b1;
                    if (wp == LAST_IDX) begin
                        state_nxt = ST_OUT;
                        wp_nxt    = '0;
                        j_nxt     = '0;
                    end else begin
                        wp_nxt = wp + 4'd1;
                    end
                end
            end
            ST_OUT: begin
                KeyOutValid = 1'b1;
                if (KeyOutReady) begin
                    if (j == LAST_IDX) begin
                        state_nxt = ST_HOLD;
                        j_nxt     = '0;
                    end else begin
                        j_nxt = j + 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                // wp is always 0 here, so a new load starts at buf[0].
                KeyInReady = 1'b1;
                if (KeyInValid) begin
                    buf_we    = 1'b1;
                    wp_nxt    = 4'd1;
                    state_nxt = ST_LOAD;
                end else if (Replay) begin
                    j_nxt     = '0;
                    state_nxt = ST_OUT;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
                wp_nxt    = '0;
                j_nxt     = '0;
            end
        endcase
        if (Clear) begin
            state_nxt = ST_LOAD;
            wp_nxt    = '0;
            j_nxt     = '0;
            buf_we    = 1'b0;
        end
    end

    // dk[j] = rk[10 - j]; the first and last keys skip InvMixColumns.
    assign rd_idx       = LAST_IDX - j;
    assign sel_word     = key_buf[rd_idx];
    assign pass_through = (EQUIV_INV == 0) || (j == 4'd0) || (j == LAST_IDX);

    inv_key_schedule_buffer_inv_mix_columns u_imc (
        .data   (sel_word),
        .result (imc_word)
    );

    assign KeyOut     = pass_through ? sel_word : imc_word;
    assign KeyOutIdx  = j;
    assign KeyOutLast = KeyOutValid && (j == LAST_IDX);

endmodule

// File: tb/tb_inv_key_schedule_buffer.sv
// tb/tb_inv_key_schedule_buffer.sv - self-checking bench with AES key-expansion reference model
module tb_inv_key_schedule_buffer;

    logic         clk = 1'b0;
    logic         rst_n, clear, key_in_valid, key_out_ready, replay;
    logic [127:0] key_in;
    logic         key_in_ready, key_out_valid, key_out_last;
    logic [127:0] key_out;
    logic [3:0]   key_out_idx;
    logic         key_in_ready_raw, key_out_valid_raw, key_out_last_raw;
    logic [127:0] key_out_raw;
    logic [3:0]   key_out_idx_raw;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] rk   [11];
    logic [127:0] obs  [11];
    logic [127:0] obs0 [11];
    logic [7:0]   sbox_tab [256];

    always #5 clk = ~clk;

    inv_key_schedule_buffer #(.EQUIV_INV(1)) dut (
        .Clk(clk), .Rst_n(rst_n), .Clear(clear),
        .KeyInValid(key_in_valid), .KeyInReady(key_in_ready), .KeyIn(key_in),
        .KeyOutValid(key_out_valid), .KeyOutReady(key_out_ready), .KeyOut(key_out),
        .KeyOutIdx(key_out_idx), .KeyOutLast(key_out_last), .Replay(replay)
    );

    inv_key_schedule_buffer #(.EQUIV_INV(0)) dut_raw (
        .Clk(clk), .Rst_n(rst_n), .Clear(clear),
        .KeyInValid(key_in_valid), .KeyInReady(key_in_ready_raw), .KeyIn(key_in),
        .KeyOutValid(key_out_valid_raw), .KeyOutReady(key_out_ready), .KeyOut(key_out_raw),
        .KeyOutIdx(key_out_idx_raw), .KeyOutLast(key_out_last_raw), .Replay(replay)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t[31:24] ^= rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [7:0] m [4] = '{8'd14, 8'd11, 8'd13, 8'd9};
        logic [127:0] o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc ^= gmul(s[127 - 8 * (4 * c + k) -: 8], m[(k - r + 4) % 4]);
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] exp_dk(input int jj);
        return (jj == 0 || jj == 10) ? rk[10 - jj] : inv_mix(rk[10 - jj]);
    endfunction

    task automatic random_key();
        expand_key({$urandom, $urandom, $urandom, $urandom});
    endtask

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input int first, input int cnt);
        for (int i = first; i < first + cnt; i++) begin
            repeat ($urandom_range(0, 2)) begin
                key_in_valid = 1'b0;
                key_in       = {$urandom, $urandom, $urandom, $urandom};
                tick();
            end
            check("load_out_valid", key_out_valid, 0);
            check("load_in_ready", key_in_ready, 1);
            key_in_valid = 1'b1;
            key_in       = rk[i];
            tick();
            key_in_valid = 1'b0;
        end
    endtask

    task automatic readout(input int cnt, input bit rand_ready);
        int n = 0;
        int cyc = 0;
        while (n < cnt && cyc < 400) begin
            check("out_valid", key_out_valid, 1);
            if (!key_out_valid) break;
            check("out_idx", key_out_idx, n);
            check("out_key", key_out, exp_dk(n));
            check("out_raw", key_out_raw, rk[10 - n]);
            check("out_last", key_out_last, n == 10);
            check("out_in_ready", key_in_ready, 0);
            obs[n]  = key_out;
            obs0[n] = key_out_raw;
            key_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (key_out_ready) n++;
            cyc++;
        end
        key_out_ready = 1'b0;
        check("handshakes", n, cnt);
        if (cnt == 11) begin
            check("hold_out_valid", key_out_valid, 0);
            check("hold_in_ready", key_in_ready, 1);
            tick();
            check("hold_stays", key_out_valid, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; key_in_valid = 1'b0; key_out_ready = 1'b0;
        replay = 1'b0; key_in = '0;
        build_sbox();
        tick(); tick();
        rst_n = 1'b1;
        check("rst_out_valid", key_out_valid, 0);
        check("rst_in_ready", key_in_ready, 1);
        check("rst_idx", key_out_idx, 0);
        check("rst_last", key_out_last, 0);

        // Known-answer key, loaded back-to-back.
        expand_key(128'h000102030405060708090a0b0c0d0e0f);
        for (int i = 0; i < 11; i++) begin
            key_in_valid = 1'b1;
            key_in       = rk[i];
            tick();
        end
        key_in_valid = 1'b0;
        check("kat_valid_next", key_out_valid, 1);
        readout(11, 0);
        check("kat_dk0", obs[0], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("kat_dk1", obs[1], 128'h13aa29be9c8faff6f770f58000f7bf03);
        check("kat_dk10", obs[10], 128'h000102030405060708090a0b0c0d0e0f);
        check("kat_raw_dk1", obs0[1], 128'h549932d1f08557681093ed9cbe2c974e);

        // Random keys, random back-pressure, then replay of the same set.
        for (int t = 0; t < 3; t++) begin
            random_key();
            load_keys(0, 11);
            check("rnd_valid_next", key_out_valid, 1);
            readout(11, 1);
            replay = 1'b1;
            tick();
            replay = 1'b0;
            check("replay_valid", key_out_valid, 1);
            readout(11, 1);
        end

        // Clear after 5 keys (with a same-cycle key handshake), Replay in LOAD ignored, full reload.
        random_key();
        load_keys(0, 5);
        clear = 1'b1; key_in_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        clear = 1'b0; key_in_valid = 1'b0;
        check("clr_out_valid", key_out_valid, 0);
        check("clr_in_ready", key_in_ready, 1);
        replay = 1'b1;
        tick();
        replay = 1'b0;
        check("load_replay_ignored", key_out_valid, 0);
        random_key();
        load_keys(0, 11);
        readout(11, 1);

        // HOLD with Replay and KeyInValid together: key wins, wp = 1.
        random_key();
        key_in_valid = 1'b1; key_in = rk[0]; replay = 1'b1;
        tick();
        key_in_valid = 1'b0; replay = 1'b0;
        check("hold_key_wins", key_out_valid, 0);
        check("hold_to_load", key_in_ready, 1);
        load_keys(1, 10);
        check("wp1_valid_next", key_out_valid, 1);
        readout(11, 1);

        // Clear mid-readout, then a fresh load.
        replay = 1'b1;
        tick();
        replay = 1'b0;
        readout(3, 1);
        clear = 1'b1; key_out_ready = 1'b1;
        tick();
        clear = 1'b0; key_out_ready = 1'b0;
        check("clr_rd_valid", key_out_valid, 0);
        check("clr_rd_idx", key_out_idx, 0);
        random_key();
        load_keys(0, 11);
        readout(11, 1);

        // Reset while reading at j = 4.
        replay = 1'b1;
        tick();
        replay = 1'b0;
        readout(4, 0);
        check("pre_rst_idx", key_out_idx, 4);
        rst_n = 1'b0; key_out_ready = 1'b1;
        tick();
        rst_n = 1'b1; key_out_ready = 1'b0;
        check("rst4_out_valid", key_out_valid, 0);
        check("rst4_in_ready", key_in_ready, 1);
        check("rst4_idx", key_out_idx, 0);
        check("rst4_last", key_out_last, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
